uart_wb_arbiter: RTL and testbench
==================================

# uart_wb_arbiter

Two-master Wishbone arbiter that shares the single 16-bit UART Wishbone slave between the CPU data port (master 0) and the debug monitor (master 1). It sits directly in front of the UART slave and owns its cyc/stb/we/sel/dat inputs. Grants are round-robin, held for the full duration of a master's cycle. A per-transfer watchdog terminates a stalled transfer with an error.

## Interface
- TIMEOUT, default 255: cycles a granted strobe may wait for ack before abort; 0 disables the watchdog; counter width is clog2(TIMEOUT+1)
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- mN_cyc_i (N=0,1)  in  1  master N bus cycle request
- mN_stb_i  in  1  master N strobe
- mN_we_i  in  1  master N write enable
- mN_sel_i  in  2  master N byte selects
- mN_dat_i  in  16  master N write data
- mN_dat_o  out  16  read data to master N, always equal to s_dat_i
- mN_ack_o  out  1  ack to master N, s_ack_i gated by grant
- mN_err_o  out  1  one-cycle timeout error to master N
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  2  slave byte selects
- s_dat_o  out  16  slave write data
- s_dat_i  in  16  slave read data
- s_ack_i  in  1  slave ack

## Operation
- States: IDLE, BUS0, BUS1. Registers: state, last (last granted master), wdog counter.
- Request N = mN_cyc_i & mN_stb_i.
- IDLE: only request 0 -> BUS0; only request 1 -> BUS1; both -> grant master != last; none -> stay. On entering BUSn, last <= n.
- BUSn: s_cyc_o = mN_cyc_i, s_stb_o = mN_stb_i, s_we_o/s_sel_o/s_dat_o = master N inputs; mN_ack_o = s_ack_i; other master's ack_o = 0.
- IDLE: s_cyc_o, s_stb_o, s_we_o = 0; s_sel_o = 0; s_dat_o = 0; both ack_o = 0.
- BUSn with mN_cyc_i = 0 -> IDLE next cycle. The other master is never granted in the same cycle as a release (one dead IDLE cycle minimum).
- Watchdog: in BUSn, wdog increments each cycle mN_stb_i & ~s_ack_i; cleared on s_ack_i, on ~mN_stb_i, and in IDLE. When wdog == TIMEOUT-1 with stb still high and no ack: mN_err_o = 1 for that cycle (combinational), s_stb_o forced 0 that cycle, state -> IDLE. The master must drop cyc on err; a master still requesting in IDLE is re-arbitrated normally (last already points to it, so a waiting peer wins).
- s_ack_i while in IDLE is ignored (no master ack).
- Multiple acks per cycle (slave acks every cycle while stb held) are passed through unchanged; the arbiter does not count transfers.

## Timing
- Reset (async): state = IDLE, last = 1 (master 0 wins first tie), wdog = 0; all outputs 0 (mN_dat_o follows s_dat_i).
- Arbitration latency: request sampled in IDLE at edge k, slave sees s_cyc_o/s_stb_o during cycle k+1.
- Slave-side signals in BUSn are combinational from master inputs; ack path slave -> master is combinational (zero added latency).
- Release: mN_cyc_i low at edge k -> IDLE in cycle k+1; earliest next grant visible in cycle k+2.
- Timeout: err asserted in the TIMEOUT-th consecutive unacked strobe cycle after grant; IDLE the following cycle.
- Reset asserted mid-transfer: immediate IDLE, s_cyc_o/s_stb_o drop asynchronously; no ack or err emitted.

## Test plan
- Single master: m0 reads while slave acks 1 cycle after stb, s_dat_i = 16'h0041 -> s_stb_o high 1 cycle after request, m0_ack_o high, m0_dat_o = 16'h0041, m1_ack_o stays 0.
- Tie after reset: m0 and m1 request in the same cycle -> BUS0 first; after m0 drops cyc, one IDLE cycle, then BUS1; second simultaneous tie -> BUS0 again (alternation).
- Grant hold: m1 granted, holds cyc for 3 writes (dat 16'h0031, 16'h0032, 16'h0033) while m0 requests -> slave sees only m1 data; m0 granted 2 cycles after m1 drops cyc.
- Timeout: TIMEOUT = 4, slave never acks m0 -> m0_err_o high exactly in the 4th strobe cycle, s_stb_o low that cycle, IDLE next; m1 waiting is granted next.
- Watchdog clear: TIMEOUT = 4, slave acks every 3rd cycle for 10 transfers -> no err.
- Async reset during BUS1 with stb high -> s_cyc_o and m1_ack_o drop within the same cycle; after release, tie goes to m0.

Source files
------------

// File: rtl/uart_wb_arbiter.sv
// uart_wb_arbiter
//
// Round-robin two-master Wishbone arbiter that shares the single 16-bit UART
// slave between the CPU data port (master 0) and the debug monitor (master 1).
// A grant is held for the whole of the granted master's cycle. A per-transfer
// watchdog aborts a strobe that waits too long for ack: the master gets a
// one-cycle err and the arbiter returns to idle.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mN_cyc_i/stb_i/we_i   master N cycle, strobe and write enable (N = 0, 1)
//   mN_sel_i, mN_dat_i    master N byte selects and write data
//   mN_dat_o              read data to master N (always s_dat_i)
//   mN_ack_o              slave ack, routed to the granted master only
//   mN_err_o              one-cycle watchdog timeout error to master N
//   s_cyc_o ... s_dat_o   Wishbone request towards the UART slave
//   s_dat_i, s_ack_i      UART slave read data and ack
//
// Parameter TIMEOUT: unacked strobe cycles allowed before abort; 0 disables.

module uart_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_sel_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam int unsigned WdW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus0, StBus1} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [WdW-1:0] wdog_q, wdog_d;

  logic        req0, req1;
  logic        gnt1;
  logic        g_cyc, g_stb, g_we;
  logic [1:0]  g_sel;
  logic [15:0] g_dat;
  logic        timeout;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Signals of whichever master currently owns the bus.
  assign gnt1  = (state_q == StBus1);
  assign g_cyc = gnt1 ? m1_cyc_i : m0_cyc_i;
  assign g_stb = gnt1 ? m1_stb_i : m0_stb_i;
  assign g_we  = gnt1 ? m1_we_i  : m0_we_i;
  assign g_sel = gnt1 ? m1_sel_i : m0_sel_i;
  assign g_dat = gnt1 ? m1_dat_i : m0_dat_i;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wdog_d   = '0;
    timeout  = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the master that was not granted last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = StBus0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = StBus1;
          last_d  = 1'b1;
        end
      end
      StBus0, StBus1: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = g_we;
        s_sel_o = g_sel;
        s_dat_o = g_dat;

        timeout = (TIMEOUT != 0) && g_stb && !s_ack_i && (wdog_q == WdLimit);

        // Counter runs only across consecutive unacked strobe cycles.
        if (g_stb && !s_ack_i && !timeout) begin
          wdog_d = wdog_q + WdW'(1);
        end

        if (timeout) begin
          s_stb_o = 1'b0;
          state_d = StIdle;
        end else if (!g_cyc) begin
          state_d = StIdle;
        end

        if (gnt1) begin
          m1_ack_o = s_ack_i;
          m1_err_o = timeout;
        end else begin
          m0_ack_o = s_ack_i;
          m0_err_o = timeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Testbench for uart_wb_arbiter (TIMEOUT = 4). Stimulus pushes the expected
// slave/master view for every cycle in which the DUT should show activity;
// a monitor compares at each falling edge when the DUT shows activity.

module tb_uart_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [1:0]  m0_sel, m1_sel;
  logic [15:0] m0_wdat, m1_wdat;
  logic [15:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [1:0]  s_sel;
  logic [15:0] s_wdat, s_rdat;
  logic        s_ack;

  uart_wb_arbiter #(.TIMEOUT(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_sel_i (m0_sel),
    .m0_dat_i (m0_wdat),
    .m0_dat_o (m0_rdat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_sel_i (m1_sel),
    .m1_dat_i (m1_wdat),
    .m1_dat_o (m1_rdat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_dat_o  (s_wdat),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic        scyc;
    logic        sstb;
    logic        swe;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic        a0;
    logic        a1;
    logic        e0;
    logic        e1;
    logic [15:0] rdat0;
    logic [15:0] rdat1;
  } obs_t;

  obs_t        sb[$];
  int unsigned cyc_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Monitor: one comparison per cycle in which the DUT shows bus activity.
  initial forever begin
    obs_t got, exp_v;
    @(negedge clk);
    if (!rst && (s_cyc || m0_ack || m1_ack || m0_err || m1_err)) begin
      got = '{cyc: cyc_cnt, scyc: s_cyc, sstb: s_stb, swe: s_we, sel: s_sel, dat: s_wdat,
              a0: m0_ack, a1: m1_ack, e0: m0_err, e1: m1_err, rdat0: m0_rdat, rdat1: m1_rdat};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_activity actual=%h required=no activity", got);
      end else begin
        exp_v = sb.pop_front();
        if (got !== exp_v) begin
          miscompares++;
          $display("FAIL bus_view cycle %0d actual=%h required=%h", exp_v.cyc, got, exp_v);
        end
      end
    end
  end

  task automatic push(input logic sstb, input logic swe, input logic [1:0] sel,
                      input logic [15:0] dat, input logic a0, input logic a1,
                      input logic e0, input logic e1);
    obs_t e;
    e = '{cyc: cyc_cnt, scyc: 1'b1, sstb: sstb, swe: swe, sel: sel, dat: dat,
          a0: a0, a1: a1, e0: e0, e1: e1, rdat0: s_rdat, rdat1: s_rdat};
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic c, input logic s, input logic w, input logic [1:0] sl,
                        input logic [15:0] d);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_sel = sl; m0_wdat = d;
  endtask

  task automatic set_m1(input logic c, input logic s, input logic w, input logic [1:0] sl,
                        input logic [15:0] d);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_sel = sl; m1_wdat = d;
  endtask

  initial begin
    set_m0(1'b1, 1'b1, 1'b1, 2'b11, 16'h1111);
    set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    s_ack  = 1'b0;
    s_rdat = 16'hBEEF;

    // Reset state, with master 0 already requesting.
    tick();
    chk("rst_s_cyc",  32'(s_cyc),   32'h0);
    chk("rst_s_stb",  32'(s_stb),   32'h0);
    chk("rst_s_we",   32'(s_we),    32'h0);
    chk("rst_s_sel",  32'(s_sel),   32'h0);
    chk("rst_s_dat",  32'(s_wdat),  32'h0);
    chk("rst_m0_ack", 32'(m0_ack),  32'h0);
    chk("rst_m1_ack", 32'(m1_ack),  32'h0);
    chk("rst_m0_err", 32'(m0_err),  32'h0);
    chk("rst_m1_err", 32'(m1_err),  32'h0);
    chk("rst_m0_dat", 32'(m0_rdat), 32'hBEEF);
    chk("rst_m1_dat", 32'(m1_rdat), 32'hBEEF);
    set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // Tie after reset goes to m0, then m1 after one dead cycle, then m0 again.
    s_rdat = 16'h1234;
    set_m0(1'b1, 1'b1, 1'b1, 2'b01, 16'hA000);
    set_m1(1'b1, 1'b1, 1'b1, 2'b10, 16'hB000);
    tick();
    s_ack = 1'b1; push(1'b1, 1'b1, 2'b01, 16'hA000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0; set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();
    tick();
    s_ack = 1'b1; push(1'b1, 1'b1, 2'b10, 16'hB000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0; set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();
    set_m0(1'b1, 1'b1, 1'b1, 2'b01, 16'hA000);
    set_m1(1'b1, 1'b1, 1'b1, 2'b10, 16'hB000);
    tick();
    s_ack = 1'b1; push(1'b1, 1'b1, 2'b01, 16'hA000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();

    // Grant hold: m1 writes three words while m0 waits.
    s_rdat = 16'h0000;
    set_m1(1'b1, 1'b1, 1'b1, 2'b11, 16'h0031);
    tick();
    set_m0(1'b1, 1'b1, 1'b1, 2'b11, 16'hDEAD);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      m1_wdat = 16'h0031 + 16'(i);
      s_ack = 1'b1;
      push(1'b1, 1'b1, 2'b11, m1_wdat, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    s_ack = 1'b0; set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();
    tick();
    s_ack = 1'b1; push(1'b1, 1'b1, 2'b11, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0; set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();

    // Stray ack while idle must not reach either master.
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;

    // Single master read, slave acks one cycle after the strobe appears.
    s_rdat = 16'h0041;
    set_m0(1'b1, 1'b1, 1'b0, 2'b11, 16'h0000);
    tick();
    push(1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    s_ack = 1'b1; push(1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0; set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();

    // Timeout: m0 never acked; err in 4th strobe cycle, then waiting m1 granted.
    s_rdat = 16'h0000;
    set_m0(1'b1, 1'b1, 1'b0, 2'b11, 16'h0000);
    tick();
    set_m1(1'b1, 1'b1, 1'b1, 2'b01, 16'h5555);
    push(1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    push(1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    push(1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    push(1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();
    s_ack = 1'b1; push(1'b1, 1'b1, 2'b01, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0; set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();

    // Watchdog clear: ack every 3rd cycle for 10 transfers, never an err.
    set_m0(1'b1, 1'b1, 1'b1, 2'b11, 16'h7700);
    tick();
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      m0_wdat = 16'h7700 + 16'(k / 3);
      s_ack   = (k % 3 == 2);
      push(1'b1, 1'b1, 2'b11, m0_wdat, s_ack, 1'b0, 1'b0, 1'b0);
    end
    tick();
    s_ack = 1'b0; set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();

    // Async reset mid-transfer on m1, then tie goes to m0.
    set_m1(1'b1, 1'b1, 1'b0, 2'b11, 16'h0000);
    tick();
    s_ack = 1'b1; push(1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_s_cyc",  32'(s_cyc),  32'h0);
    chk("arst_s_stb",  32'(s_stb),  32'h0);
    chk("arst_m1_ack", 32'(m1_ack), 32'h0);
    tick();
    s_ack = 1'b0; set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    set_m0(1'b1, 1'b1, 1'b1, 2'b01, 16'hC0DE);
    set_m1(1'b1, 1'b1, 1'b1, 2'b10, 16'hF00D);
    tick();
    s_ack = 1'b1; push(1'b1, 1'b1, 2'b01, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    set_m1(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    repeat (3) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
